// File: rtl/and_cascade_tester_if.sv
// Bus between the cascade self-tester and the AND-reduction cascade under test.
// master is the tester side; slave is the cascade side.
interface and_cascade_tester_if #(
    parameter int LENGTH = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [LENGTH-1:0] a_out;
    logic              c_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic              fail_valid;
    logic [LENGTH-1:0] first_fail;

    modport master (
        input  start, c_in,
        output a_out, busy, done, pass, err_count, fail_valid, first_fail
    );

    modport slave (
        output start, c_in,
        input  a_out, busy, done, pass, err_count, fail_valid, first_fail
    );
endinterface

// File: rtl/and_cascade_tester.sv
// Exhaustive self-test driver for a LENGTH-bit AND-reduction cascade: sweeps every
// pattern, compares the returned bit against &pattern, counts errors, logs first failure.
module and_cascade_tester #(
    parameter int LENGTH = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    and_cascade_tester_if.master bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    state_t            state;
    logic [LENGTH-1:0] pattern;
    logic [LENGTH-1:0] first_fail;
    logic [SW-1:0]     settle_cnt;
    logic [CNT_W-1:0]  err_count;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail_valid;
    logic              expected;

    // Error counter sticks at all-ones rather than wrapping back to a clean-looking value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign expected = &pattern;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pattern    <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pattern    <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (bus.c_in != expected) begin
                        err_count <= sat_inc(err_count);
                        if (!fail_valid) begin
                            first_fail <= pattern;
                            fail_valid <= 1'b1;
                        end
                    end
                    // The last pattern is all-ones; stop there instead of wrapping to zero.
                    if (&pattern) begin
                        state <= FINISH;
                    end else begin
                        pattern <= pattern + 1'b1;
                        state   <= DRIVE;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out      = pattern;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_count  = err_count;
    assign bus.fail_valid = fail_valid;
    assign bus.first_fail = first_fail;
endmodule

// File: tb/tb_and_cascade_tester.sv
// Directed bench for and_cascade_tester: ideal, stuck-at, saturating, delayed cascade
// models, plus mid-sweep reset and ignored start pulses.
module tb_and_cascade_tester;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    int   checks = 0;
    int   errors = 0;
    int   cycles;
    logic c1 = 1'b0, c2 = 1'b0, d1 = 1'b0, d2 = 1'b0;

    always #5 clk = ~clk;

    and_cascade_tester_if #(.LENGTH(8), .CNT_W(16)) ifa ();
    and_cascade_tester_if #(.LENGTH(8), .CNT_W(4))  ifb ();
    and_cascade_tester_if #(.LENGTH(8), .CNT_W(16)) ifc ();
    and_cascade_tester_if #(.LENGTH(8), .CNT_W(16)) ifd ();

    and_cascade_tester #(.LENGTH(8), .SETTLE(1), .CNT_W(16)) ua (.clk(clk), .rst(rst), .bus(ifa));
    and_cascade_tester #(.LENGTH(8), .SETTLE(1), .CNT_W(4))  ub (.clk(clk), .rst(rst), .bus(ifb));
    and_cascade_tester #(.LENGTH(8), .SETTLE(3), .CNT_W(16)) uc (.clk(clk), .rst(rst), .bus(ifc));
    and_cascade_tester #(.LENGTH(8), .SETTLE(1), .CNT_W(16)) ud (.clk(clk), .rst(rst), .bus(ifd));

    // Cascade models: A selectable (ideal / stuck-0 / stuck-1), B stuck-1, C and D ideal behind two registers.
    assign ifa.c_in = (mode == 0) ? &ifa.a_out : (mode == 1) ? 1'b0 : 1'b1;
    assign ifb.c_in = 1'b1;
    always @(posedge clk) begin
        c1 <= &ifc.a_out;
        c2 <= c1;
        d1 <= &ifd.a_out;
        d2 <= d1;
    end
    assign ifc.c_in = c2;
    assign ifd.c_in = d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: ifa.start = v;
            1: ifb.start = v;
            2: ifc.start = v;
            default: ifd.start = v;
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return ifa.done;
            1: return ifb.done;
            2: return ifc.done;
            default: return ifd.done;
        endcase
    endfunction

    // Returns cycles from the start edge to the first cycle done is seen high (-1 on timeout).
    task automatic run(input int which, input int extra, output int n);
        @(negedge clk) set_start(which, 1'b1);
        @(negedge clk) set_start(which, 1'b0);
        n = -1;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (k == extra) set_start(which, 1'b1);
            if (k == extra + 1) set_start(which, 1'b0);
            if (which == 0 && k == 10) check("busy_mid_sweep", ifa.busy, 1);
            if (get_done(which)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_a_out"}, ifa.a_out, 0);
        check({tag, "_busy"}, ifa.busy, 0);
        check({tag, "_done"}, ifa.done, 0);
        check({tag, "_pass"}, ifa.pass, 0);
        check({tag, "_err_count"}, ifa.err_count, 0);
        check({tag, "_fail_valid"}, ifa.fail_valid, 0);
        check({tag, "_first_fail"}, ifa.first_fail, 0);
    endtask

    initial begin
        logic seen_done;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        ifd.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_a_zero("reset");

        // Ideal cascade
        run(0, 0, cycles);
        check("ideal_latency", cycles, 513);
        check("ideal_err_count", ifa.err_count, 0);
        check("ideal_pass", ifa.pass, 1);
        check("ideal_fail_valid", ifa.fail_valid, 0);
        check("ideal_busy_at_done", ifa.busy, 0);
        check("ideal_a_out_held", ifa.a_out, 8'hFF);
        @(negedge clk);
        check("done_one_cycle", ifa.done, 0);
        check("pass_held", ifa.pass, 1);

        // Stuck at 0: only 0xFF mismatches
        mode = 1;
        run(0, 0, cycles);
        check("stuck0_latency", cycles, 513);
        check("stuck0_err_count", ifa.err_count, 1);
        check("stuck0_first_fail", ifa.first_fail, 8'hFF);
        check("stuck0_fail_valid", ifa.fail_valid, 1);
        check("stuck0_pass", ifa.pass, 0);

        // Stuck at 1: every pattern except 0xFF mismatches
        mode = 2;
        run(0, 0, cycles);
        check("stuck1_err_count", ifa.err_count, 255);
        check("stuck1_first_fail", ifa.first_fail, 8'h00);
        check("stuck1_fail_valid", ifa.fail_valid, 1);
        check("stuck1_pass", ifa.pass, 0);

        // Stuck at 1 with a 4-bit counter saturates
        run(1, 0, cycles);
        check("sat_latency", cycles, 513);
        check("sat_err_count", ifb.err_count, 4'hF);
        check("sat_first_fail", ifb.first_fail, 8'h00);
        check("sat_pass", ifb.pass, 0);

        // Two-register delayed cascade with enough settle time
        run(2, 0, cycles);
        check("delay_s3_latency", cycles, 1025);
        check("delay_s3_err_count", ifc.err_count, 0);
        check("delay_s3_pass", ifc.pass, 1);

        // Same delay with too little settle time
        run(3, 0, cycles);
        check("delay_s1_latency", cycles, 513);
        check("delay_s1_err_nonzero", (ifd.err_count != 0), 1);
        check("delay_s1_pass", ifd.pass, 0);

        // Extra start mid-sweep is ignored
        mode = 0;
        run(0, 50, cycles);
        check("extra_start_latency", cycles, 513);
        check("extra_start_err_count", ifa.err_count, 0);
        check("extra_start_pass", ifa.pass, 1);

        // Reset 100 cycles into a failing sweep
        mode = 2;
        @(negedge clk) ifa.start = 1'b1;
        @(negedge clk) ifa.start = 1'b0;
        repeat (99) @(negedge clk);
        check("pre_abort_busy", ifa.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_a_zero("abort");
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (ifa.done) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_stays_idle", ifa.busy, 0);

        // Fresh sweep after reset
        mode = 0;
        run(0, 0, cycles);
        check("fresh_latency", cycles, 513);
        check("fresh_err_count", ifa.err_count, 0);
        check("fresh_pass", ifa.pass, 1);
        check("fresh_fail_valid", ifa.fail_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
